vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter.sv | 157 +++++++++++++++
 tb/tb_vram_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Frame-buffer arbiter: display reads have absolute priority, host gets idle slots.
// Optional VRAM_ARB_HOST_BLANK_ONLY_EN restricts host access to blanking time.
module vram_arbiter #(
    parameter int ADDR_W        = 19,
    parameter int DATA_W        = 8,
    parameter int HOST_WAIT_MAX = 800
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RGB_EN,
    input  logic              DISP_REQ,
    input  logic [ADDR_W-1:0] DISP_ADDR,
    output logic [DATA_W-1:0] DISP_DATA,
    output logic              DISP_VALID,
    input  logic              HOST_REQ,
    input  logic              HOST_WE,
    input  logic [ADDR_W-1:0] HOST_ADDR,
    input  logic [DATA_W-1:0] HOST_WDATA,
    output logic [DATA_W-1:0] HOST_RDATA,
    output logic              HOST_ACK,
    output logic              HOST_STARVE,
    output logic              MEM_EN,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic [DATA_W-1:0] MEM_RDATA
);

    localparam int CNT_W = $clog2(HOST_WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(HOST_WAIT_MAX);

    typedef enum logic [1:0] {S_IDLE, S_ISSUED, S_DONE} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_DISP, OWN_HOST} own_t;

    state_t            r_state;
    state_t            w_state_nxt;
    own_t              r_tag1;
    own_t              r_tag2;
    logic              r_host_we;
    logic [CNT_W-1:0]  r_wait;
    logic [CNT_W-1:0]  w_wait_nxt;
    logic              r_starve;
    logic              w_blank_ok;
    logic              w_host_grant;
    logic              w_wait_inc;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_disp_data;
    logic              r_disp_valid;
    logic [DATA_W-1:0] r_host_rdata;
    logic              r_host_ack;

`ifdef VRAM_ARB_HOST_BLANK_ONLY_EN
    assign w_blank_ok = ~RGB_EN;
`else
    logic w_unused_rgb;
    assign w_unused_rgb = RGB_EN;
    assign w_blank_ok   = 1'b1;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_host_grant) w_state_nxt = S_ISSUED;
            S_ISSUED: w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_host_grant = ~DISP_REQ & HOST_REQ & w_blank_ok
                     & (r_state == S_IDLE);
        w_wait_inc   = HOST_REQ & w_blank_ok & ~w_host_grant
                     & (r_state == S_IDLE);
    end

    always_comb begin
        w_wait_nxt = r_wait;
        if (w_host_grant)
            w_wait_nxt = '0;
        else if (w_wait_inc && r_wait != WAIT_MAX)
            w_wait_nxt = r_wait + 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wait   <= '0;
            r_starve <= 1'b0;
        end else begin
            r_wait   <= w_wait_nxt;
            r_starve <= r_starve | (w_wait_nxt == WAIT_MAX);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_tag1      <= OWN_NONE;
            r_tag2      <= OWN_NONE;
            r_host_we   <= 1'b0;
        end else begin
            r_mem_en <= DISP_REQ | w_host_grant;
            r_mem_we <= w_host_grant & HOST_WE;
            r_tag2   <= r_tag1;
            if (DISP_REQ) begin
                r_mem_addr <= DISP_ADDR;
                r_tag1     <= OWN_DISP;
            end else if (w_host_grant) begin
                r_mem_addr <= HOST_ADDR;
                r_tag1     <= OWN_HOST;
                r_host_we  <= HOST_WE;
                if (HOST_WE) r_mem_wdata <= HOST_WDATA;
            end else begin
                r_tag1 <= OWN_NONE;
            end
        end
    end

    // Read data lands two edges after issue; the stage-2 tag routes it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_disp_data  <= '0;
            r_disp_valid <= 1'b0;
            r_host_rdata <= '0;
            r_host_ack   <= 1'b0;
        end else begin
            r_disp_valid <= (r_tag2 == OWN_DISP);
            r_host_ack   <= (r_state == S_DONE);
            if (r_tag2 == OWN_DISP)
                r_disp_data <= MEM_RDATA;
            if (r_tag2 == OWN_HOST && !r_host_we)
                r_host_rdata <= MEM_RDATA;
        end
    end

    assign DISP_DATA   = r_disp_data;
    assign DISP_VALID  = r_disp_valid;
    assign HOST_RDATA  = r_host_rdata;
    assign HOST_ACK    = r_host_ack;
    assign HOST_STARVE = r_starve;
    assign MEM_EN      = r_mem_en;
    assign MEM_WE      = r_mem_we;
    assign MEM_ADDR    = r_mem_addr;
    assign MEM_WDATA   = r_mem_wdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a 1-cycle-latency frame-buffer model.
// Unwritten RAM words read as (addr[7:0] + 0x40).
module tb_vram_arbiter;

    localparam int AW = 19;
    localparam int DW = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          RGB_EN = 1'b0;
    logic          DISP_REQ = 1'b0;
    logic [AW-1:0] DISP_ADDR = '0;
    logic [DW-1:0] DISP_DATA;
    logic          DISP_VALID;
    logic          HOST_REQ = 1'b0;
    logic          HOST_WE = 1'b0;
    logic [AW-1:0] HOST_ADDR = '0;
    logic [DW-1:0] HOST_WDATA = '0;
    logic [DW-1:0] HOST_RDATA;
    logic          HOST_ACK;
    logic          HOST_STARVE;
    logic          MEM_EN;
    logic          MEM_WE;
    logic [AW-1:0] MEM_ADDR;
    logic [DW-1:0] MEM_WDATA;
    logic [DW-1:0] MEM_RDATA = '0;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] wr_data [0:1023];
    logic          wr_flag [0:1023];

    vram_arbiter dut (
        .CLK(CLK), .RST(RST), .RGB_EN(RGB_EN),
        .DISP_REQ(DISP_REQ), .DISP_ADDR(DISP_ADDR),
        .DISP_DATA(DISP_DATA), .DISP_VALID(DISP_VALID),
        .HOST_REQ(HOST_REQ), .HOST_WE(HOST_WE),
        .HOST_ADDR(HOST_ADDR), .HOST_WDATA(HOST_WDATA),
        .HOST_RDATA(HOST_RDATA), .HOST_ACK(HOST_ACK),
        .HOST_STARVE(HOST_STARVE),
        .MEM_EN(MEM_EN), .MEM_WE(MEM_WE),
        .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
        .MEM_RDATA(MEM_RDATA)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 1024; i++) wr_flag[i] <= 1'b0;
        end else if (MEM_EN) begin
            if (MEM_WE) begin
                wr_flag[MEM_ADDR[9:0]] <= 1'b1;
                wr_data[MEM_ADDR[9:0]] <= MEM_WDATA;
            end else if (wr_flag[MEM_ADDR[9:0]]) begin
                MEM_RDATA <= wr_data[MEM_ADDR[9:0]];
            end else begin
                MEM_RDATA <= MEM_ADDR[7:0] + 8'h40;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_out();
        return {16'h0, DISP_DATA, DISP_VALID, HOST_RDATA, HOST_ACK,
                HOST_STARVE, MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA};
    endfunction

    logic host_seen;

    initial begin
        // reset state
        tick();
        tick();
        chk("reset_outputs", all_out(), 64'h0);
        RST = 1'b0;

        // display burst, addresses 0..3
        for (int i = 0; i < 8; i++) begin
            DISP_REQ  = (i < 4);
            DISP_ADDR = AW'(i);
            tick();
            if (i == 0) chk("burst_mem_en", {63'h0, MEM_EN}, 64'h1);
            chk("burst_valid", {63'h0, DISP_VALID},
                {63'h0, (i >= 2 && i <= 5)});
            if (i >= 2 && i <= 5)
                chk("burst_data", {56'h0, DISP_DATA}, 64'(8'h40 + i - 2));
        end

        // host write 0xA5 to 100, then read back
        HOST_REQ = 1'b1; HOST_WE = 1'b1;
        HOST_ADDR = AW'(100); HOST_WDATA = 8'hA5;
        tick();
        chk("wr_issue", {MEM_EN, MEM_WE, MEM_WDATA, 5'h0, MEM_ADDR},
            {1'b1, 1'b1, 8'hA5, 5'h0, 19'd100});
        tick();
        chk("wr_ack_early", {63'h0, HOST_ACK}, 64'h0);
        tick();
        chk("wr_ack", {63'h0, HOST_ACK}, 64'h1);
        chk("wr_rdata_kept", {56'h0, HOST_RDATA}, 64'h0);
        HOST_WE = 1'b0;
        tick();
        chk("rd_issue", {62'h0, MEM_EN, MEM_WE}, 64'h2);
        chk("rd_ack_off", {63'h0, HOST_ACK}, 64'h0);
        tick();
        chk("rd_ack_early", {63'h0, HOST_ACK}, 64'h0);
        tick();
        chk("rd_ack", {63'h0, HOST_ACK}, 64'h1);
        chk("rd_rdata", {56'h0, HOST_RDATA}, 64'hA5);
        HOST_REQ = 1'b0;
        tick();
        chk("ack_one_cycle", {63'h0, HOST_ACK}, 64'h0);
        chk("idle_mem_en", {62'h0, MEM_EN, MEM_WE}, 64'h0);

        // simultaneous display and host requests
        DISP_REQ = 1'b1; DISP_ADDR = AW'(5);
        HOST_REQ = 1'b1; HOST_ADDR = AW'(7);
        tick();
        chk("coll_disp_first", {45'h0, MEM_ADDR}, 64'd5);
        DISP_REQ = 1'b0;
        tick();
        chk("coll_host_next", {44'h0, MEM_EN, MEM_ADDR},
            {44'h0, 1'b1, 19'd7});
        tick();
        chk("coll_disp_data", {55'h0, DISP_VALID, DISP_DATA},
            {55'h0, 1'b1, 8'h45});
        tick();
        chk("coll_host_data", {55'h0, HOST_ACK, HOST_RDATA},
            {55'h0, 1'b1, 8'h47});
        HOST_REQ = 1'b0;
        tick();

        // starvation under continuous display traffic
        DISP_REQ = 1'b1; DISP_ADDR = AW'(0);
        HOST_REQ = 1'b1; HOST_ADDR = AW'(3);
        host_seen = 1'b0;
        for (int n = 1; n < 800; n++) begin
            tick();
            if (MEM_ADDR != '0) host_seen = 1'b1;
        end
        chk("starve_no_grant", {63'h0, host_seen}, 64'h0);
        chk("starve_799", {63'h0, HOST_STARVE}, 64'h0);
        tick();
        chk("starve_800", {63'h0, HOST_STARVE}, 64'h1);
        for (int n = 0; n < 5; n++) tick();
        chk("starve_sticky", {63'h0, HOST_STARVE}, 64'h1);
        DISP_REQ = 1'b0;
        tick();
        chk("starve_grant", {45'h0, MEM_ADDR}, 64'd3);
        chk("starve_after_grant", {63'h0, HOST_STARVE}, 64'h1);
        tick();
        tick();
        chk("starve_ack", {55'h0, HOST_ACK, HOST_RDATA},
            {55'h0, 1'b1, 8'h43});
        HOST_REQ = 1'b0;
        tick();

        // reset one cycle after a host grant
        HOST_REQ = 1'b1; HOST_ADDR = AW'(7);
        tick();
        chk("rst_pre_grant", {63'h0, MEM_EN}, 64'h1);
        RST = 1'b1;
        #1;
        chk("rst_async_out", all_out(), 64'h0);
        HOST_REQ = 1'b0;
        tick();
        tick();
        chk("rst_held_out", all_out(), 64'h0);
        RST = 1'b0;
        DISP_REQ = 1'b1; DISP_ADDR = AW'(2);
        tick();
        chk("rst_first_edge", {44'h0, MEM_EN, MEM_ADDR},
            {44'h0, 1'b1, 19'd2});
        chk("rst_no_ack0", {63'h0, HOST_ACK}, 64'h0);
        DISP_REQ = 1'b0;
        tick();
        chk("rst_no_ack1", {63'h0, HOST_ACK}, 64'h0);
        tick();
        chk("rst_disp", {54'h0, HOST_ACK, DISP_VALID, DISP_DATA},
            {54'h0, 1'b0, 1'b1, 8'h42});

        // RGB_EN gating of host access
        RGB_EN = 1'b1;
        HOST_REQ = 1'b1; HOST_WE = 1'b0; HOST_ADDR = AW'(9);
`ifdef VRAM_ARB_HOST_BLANK_ONLY_EN
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("blank_hold", {63'h0, MEM_EN}, 64'h0);
        end
        RGB_EN = 1'b0;
        tick();
        chk("blank_grant", {44'h0, MEM_EN, MEM_ADDR},
            {44'h0, 1'b1, 19'd9});
`else
        tick();
        chk("rgb_ignored", {44'h0, MEM_EN, MEM_ADDR},
            {44'h0, 1'b1, 19'd9});
`endif
        tick();
        tick();
        chk("rgb_ack", {55'h0, HOST_ACK, HOST_RDATA},
            {55'h0, 1'b1, 8'h49});
        HOST_REQ = 1'b0;
        RGB_EN = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
